// File: rtl/pong_pkg.sv
// Shared encodings and constants for the Pong match controller.
// The width helper is reused by both paddle width datapaths.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RALLY     = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] HIT_P1   = 2'b10;
    localparam logic [1:0] HIT_P2   = 2'b01;
    localparam logic [1:0] MISS_P1  = 2'b10;
    localparam logic [1:0] MISS_P2  = 2'b01;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_P2   = 2'b01;

    localparam int W_DEFAULT_PX = 150;
    localparam int W_MIN_PX     = 50;
    localparam int W_STEP_PX    = 11;

    // Compare before subtracting so the width can never wrap below the floor.
    function automatic logic [9:0] shrink_width(input logic [9:0] width,
                                                input logic [9:0] w_min,
                                                input logic [9:0] w_step);
        logic [9:0] limit;
        limit = w_min + w_step;
        if (width > limit) begin
            return width - w_step;
        end else begin
            return w_min;
        end
    endfunction

endpackage

// File: rtl/pong_match_controller_paddle_width_ctrl.sv
// One paddle's width register: shrinks by a step per hit, clamps at the
// minimum, and snaps back to the default on restore (restore wins).
module paddle_width_ctrl
    import pong_pkg::*;
#(
    parameter int W_DEFAULT = W_DEFAULT_PX,
    parameter int W_MIN     = W_MIN_PX,
    parameter int W_STEP    = W_STEP_PX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shrink,
    input  logic       restore,
    output logic [9:0] width
);

    localparam logic [9:0] W_DEFAULT_C = 10'(W_DEFAULT);
    localparam logic [9:0] W_MIN_C     = 10'(W_MIN);
    localparam logic [9:0] W_STEP_C    = 10'(W_STEP);

    // Width register with restore priority over shrink.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width <= W_DEFAULT_C;
        end else if (restore) begin
            width <= W_DEFAULT_C;
        end else if (shrink) begin
            width <= shrink_width(width, W_MIN_C, W_STEP_C);
        end else begin
            width <= width;
        end
    end

endmodule

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve/rally/point/game-over FSM, scores, edge
// detection of hit/miss, and the two paddle width datapaths.
module pong_match_controller
    import pong_pkg::*;
#(
    parameter int W_DEFAULT    = W_DEFAULT_PX,
    parameter int W_MIN        = W_MIN_PX,
    parameter int W_STEP       = W_STEP_PX,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [1:0] hit,
    input  logic [1:0] miss,
    output logic       ball_enable,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [9:0] paddle1_width,
    output logic [9:0] paddle2_width,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN_C      = 4'(WIN_SCORE);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] hit_prev, miss_prev;
    logic [1:0] hit_rise, miss_rise;
    logic [3:0] score1_nxt, score2_nxt;
    logic [1:0] winner_nxt;
    logic       serve_dir_nxt;
    logic       shrink1, shrink2, restore;

    assign hit_rise  = hit & ~hit_prev;
    assign miss_rise = miss & ~miss_prev;
    assign state_o   = state;

    // State, counter, score and ball-control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            hit_prev    <= 2'b00;
            miss_prev   <= 2'b00;
            score1      <= 4'd0;
            score2      <= 4'd0;
            winner      <= WIN_NONE;
            serve_dir   <= 1'b0;
            ball_enable <= 1'b0;
            ball_center <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hit_prev    <= hit;
            miss_prev   <= miss;
            score1      <= score1_nxt;
            score2      <= score2_nxt;
            winner      <= winner_nxt;
            serve_dir   <= serve_dir_nxt;
            ball_enable <= (state_nxt == ST_RALLY);
            ball_center <= (state_nxt != ST_RALLY);
        end
    end

    // Next-state and datapath control; hit and miss only matter in RALLY.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        score1_nxt    = score1;
        score2_nxt    = score2;
        winner_nxt    = winner;
        serve_dir_nxt = serve_dir;
        shrink1       = 1'b0;
        shrink2       = 1'b0;
        restore       = 1'b0;
        case (state)
            ST_IDLE: begin
                score1_nxt = 4'd0;
                score2_nxt = 4'd0;
                winner_nxt = WIN_NONE;
                cnt_nxt    = 8'd0;
                restore    = 1'b1;
                if (start) begin
                    state_nxt = ST_SERVE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (frame_tick && (cnt == SERVE_LAST)) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = ST_RALLY;
                end else if (frame_tick) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    cnt_nxt = cnt;
                end
            end
            ST_RALLY: begin
                if (miss_rise != 2'b00) begin
                    restore   = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = ST_POINT;
                    case (miss_rise)
                        MISS_P2: begin
                            score1_nxt    = score1 + 4'd1;
                            serve_dir_nxt = 1'b1;
                        end
                        MISS_P1: begin
                            score2_nxt    = score2 + 4'd1;
                            serve_dir_nxt = 1'b0;
                        end
                        default: begin
                            serve_dir_nxt = ~serve_dir;
                        end
                    endcase
                end else begin
                    shrink1 = (hit_rise == HIT_P1);
                    shrink2 = (hit_rise == HIT_P2);
                end
            end
            ST_POINT: begin
                if (score1 == WIN_C) begin
                    winner_nxt = WIN_P1;
                    state_nxt  = ST_GAME_OVER;
                end else if (score2 == WIN_C) begin
                    winner_nxt = WIN_P2;
                    state_nxt  = ST_GAME_OVER;
                end else if (frame_tick && (cnt == POINT_LAST)) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = ST_SERVE;
                end else if (frame_tick) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    cnt_nxt = cnt;
                end
            end
            ST_GAME_OVER: begin
                if (start) begin
                    score1_nxt = 4'd0;
                    score2_nxt = 4'd0;
                    winner_nxt = WIN_NONE;
                    cnt_nxt    = 8'd0;
                    restore    = 1'b1;
                    state_nxt  = ST_SERVE;
                end else begin
                    state_nxt = ST_GAME_OVER;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    paddle_width_ctrl #(
        .W_DEFAULT (W_DEFAULT),
        .W_MIN     (W_MIN),
        .W_STEP    (W_STEP)
    ) u_paddle1 (
        .clk     (clk),
        .reset   (reset),
        .shrink  (shrink1),
        .restore (restore),
        .width   (paddle1_width)
    );

    paddle_width_ctrl #(
        .W_DEFAULT (W_DEFAULT),
        .W_MIN     (W_MIN),
        .W_STEP    (W_STEP)
    ) u_paddle2 (
        .clk     (clk),
        .reset   (reset),
        .shrink  (shrink2),
        .restore (restore),
        .width   (paddle2_width)
    );

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed match scenarios followed by random
// play, every cycle compared against a rule-level model of the match.
module tb_pong_match_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] hit = 2'b00;
    logic [1:0] miss = 2'b00;
    logic       ball_enable, ball_center, serve_dir;
    logic [9:0] paddle1_width, paddle2_width;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // Reference model, expressed as match rules rather than hardware.
    int m_phase, m_frames, m_w1, m_w2, m_s1, m_s2, m_winner, m_dir;
    int m_phit, m_pmiss;

    int p1_seq[12] = '{139, 128, 117, 106, 95, 84, 73, 62, 51, 50, 50, 50};

    pong_match_controller dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .frame_tick    (frame_tick),
        .hit           (hit),
        .miss          (miss),
        .ball_enable   (ball_enable),
        .ball_center   (ball_center),
        .serve_dir     (serve_dir),
        .paddle1_width (paddle1_width),
        .paddle2_width (paddle2_width),
        .score1        (score1),
        .score2        (score2),
        .winner        (winner),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int shrunk(input int w);
        return (w - 11 < 50) ? 50 : w - 11;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_frames = 0; m_w1 = 150; m_w2 = 150;
        m_s1 = 0; m_s2 = 0; m_winner = 0; m_dir = 0; m_phit = 0; m_pmiss = 0;
    endtask

    task automatic new_match();
        m_s1 = 0; m_s2 = 0; m_winner = 0; m_w1 = 150; m_w2 = 150;
        m_frames = 0; m_phase = 1;
    endtask

    // Phases: 0 idle, 1 serve, 2 rally, 3 point, 4 game over.
    task automatic model_step();
        int hr, mr;
        hr = int'(hit) & ~m_phit & 3;
        mr = int'(miss) & ~m_pmiss & 3;
        m_phit = int'(hit);
        m_pmiss = int'(miss);
        if (m_phase == 0) begin
            if (start) new_match();
        end else if (m_phase == 1) begin
            if (frame_tick) m_frames++;
            if (m_frames == 60) begin m_frames = 0; m_phase = 2; end
        end else if (m_phase == 2) begin
            if (mr != 0) begin
                m_w1 = 150; m_w2 = 150; m_phase = 3; m_frames = 0;
                if (mr == 1) begin m_s1++; m_dir = 1; end
                else if (mr == 2) begin m_s2++; m_dir = 0; end
                else m_dir = 1 - m_dir;
            end else if (hr == 2) m_w1 = shrunk(m_w1);
            else if (hr == 1) m_w2 = shrunk(m_w2);
        end else if (m_phase == 3) begin
            if (m_s1 == 7) begin m_winner = 2; m_phase = 4; end
            else if (m_s2 == 7) begin m_winner = 1; m_phase = 4; end
            else begin
                if (frame_tick) m_frames++;
                if (m_frames == 90) begin m_frames = 0; m_phase = 1; end
            end
        end else begin
            if (start) new_match();
        end
    endtask

    task automatic check_all();
        check_val("state", 32'(state_o), 32'(m_phase));
        check_val("ball_enable", 32'(ball_enable), 32'(m_phase == 2));
        check_val("ball_center", 32'(ball_center), 32'(m_phase != 2));
        check_val("serve_dir", 32'(serve_dir), 32'(m_dir));
        check_val("paddle1_width", 32'(paddle1_width), 32'(m_w1));
        check_val("paddle2_width", 32'(paddle2_width), 32'(m_w2));
        check_val("score1", 32'(score1), 32'(m_s1));
        check_val("score2", 32'(score2), 32'(m_s2));
        check_val("winner", 32'(winner), 32'(m_winner));
    endtask

    task automatic cycle(input logic s, input logic f, input logic [1:0] h, input logic [1:0] m);
        start = s; frame_tick = f; hit = h; miss = m;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 2'b00, 2'b00);
    endtask

    task automatic do_point(input logic [1:0] m);
        ticks(60);
        cycle(1'b0, 1'b0, 2'b00, m);
        cycle(1'b0, 1'b0, 2'b00, 2'b00);
        ticks(90);
    endtask

    task automatic pulse_hit(input logic [1:0] h);
        cycle(1'b0, 1'b0, h, 2'b00);
        cycle(1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check_val("reset_width", 32'(paddle1_width), 32'd150);
        reset = 1'b0;

        cycle(1'b1, 1'b0, 2'b00, 2'b00);
        check_val("start_serve", 32'(state_o), 32'd1);
        cycle(1'b0, 1'b0, 2'b00, 2'b00);
        ticks(60);
        check_val("rally_enable", 32'(ball_enable), 32'd1);

        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 1'b0, 2'b10, 2'b00);
            check_val("p1_shrink_seq", 32'(paddle1_width), 32'(p1_seq[k]));
            cycle(1'b0, 1'b0, 2'b00, 2'b00);
        end
        check_val("p2_untouched", 32'(paddle2_width), 32'd150);

        pulse_hit(2'b11);
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 2'b01, 2'b00);
        check_val("p2_held_once", 32'(paddle2_width), 32'd139);
        cycle(1'b0, 1'b0, 2'b00, 2'b00);

        cycle(1'b0, 1'b0, 2'b00, 2'b01);
        check_val("miss_score1", 32'(score1), 32'd1);
        check_val("miss_dir", 32'(serve_dir), 32'd1);
        check_val("miss_restore", 32'(paddle1_width), 32'd150);
        cycle(1'b0, 1'b0, 2'b00, 2'b00);
        ticks(90);
        check_val("point_to_serve", 32'(state_o), 32'd1);

        for (int k = 0; k < 7; k++) do_point(2'b10);
        check_val("game_over", 32'(state_o), 32'd4);
        check_val("winner_p2", 32'(winner), 32'd1);
        check_val("score2_win", 32'(score2), 32'd7);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 2'b10, 2'b01);
            cycle(1'b0, 1'b0, 2'b00, 2'b00);
        end
        cycle(1'b1, 1'b0, 2'b00, 2'b00);
        check_val("restart_score", 32'(score2), 32'd0);
        cycle(1'b0, 1'b0, 2'b00, 2'b00);

        for (int k = 0; k < 3; k++) do_point(2'b01);
        for (int k = 0; k < 2; k++) do_point(2'b10);
        ticks(60);
        for (int k = 0; k < 6; k++) pulse_hit(2'b10);
        for (int k = 0; k < 8; k++) pulse_hit(2'b01);
        check_val("pre_rst_w1", 32'(paddle1_width), 32'd84);
        check_val("pre_rst_w2", 32'(paddle2_width), 32'd62);
        check_val("pre_rst_s1", 32'(score1), 32'd3);
        check_val("pre_rst_s2", 32'(score2), 32'd2);
        mid_reset();
        check_val("rst_idle", 32'(state_o), 32'd0);
        check_val("rst_center", 32'(ball_center), 32'd1);

        for (int i = 0; i < 12000; i++) begin
            logic       s, f;
            logic [1:0] h, m;
            s = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 1) == 0);
            h = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : hit;
            m = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(0, 3)) : miss;
            cycle(s, f, h, m);
            if (i % 4000 == 3999) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
